// File: rtl/ct_spsram_256x144_arb.sv
// Round-robin two-requester sequencer for one 256x144 single-port SRAM; grant is same-cycle, read valid 1 cycle later.
// Losing requesters hold req until granted. Define CT_SPSRAM_ARB_INIT_EN for the post-reset zero sweep (busy, no grants).
module ct_spsram_256x144_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 144,
  parameter int INIT_LAST  = 255
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  r0_req,
  input  logic                  r0_gwen,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_din,
  input  logic [DATA_WIDTH-1:0] r0_wen,
  output logic                  r0_gnt,
  input  logic                  r1_req,
  input  logic                  r1_gwen,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_din,
  input  logic [DATA_WIDTH-1:0] r1_wen,
  output logic                  r1_gnt,
  output logic                  rd0_vld,
  output logic                  rd1_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  arb_busy,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic                  idle;
  logic                  rr_ptr;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef CT_SPSRAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INIT_LAST);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter parks on the last address rather than wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_INIT) begin
      if (cnt == LAST_ADDR) state_nxt = ST_IDLE;
      else                  cnt_nxt   = cnt + ADDR_WIDTH'(1);
    end
  end

  assign idle      = (state == ST_IDLE);
  assign init_addr = cnt;
`else
  assign idle      = 1'b1;
  assign init_addr = '0;
`endif

  assign arb_busy = ~idle;

  // rr_ptr only breaks ties; a lone requester always wins.
  assign r0_gnt = idle & r0_req & (~r1_req | ~rr_ptr);
  assign r1_gnt = idle & r1_req & (~r0_req |  rr_ptr);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_ptr  <= 1'b0;
      rd0_vld <= 1'b0;
      rd1_vld <= 1'b0;
    end else begin
      if (r0_gnt)      rr_ptr <= 1'b1;
      else if (r1_gnt) rr_ptr <= 1'b0;
      rd0_vld <= r0_gnt & r0_gwen;
      rd1_vld <= r1_gnt & r1_gwen;
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    sram_wen  = '1;
    if (!idle) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_addr = init_addr;
      sram_wen  = '0;
    end else if (r0_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = r0_gwen;
      sram_addr = r0_addr;
      sram_din  = r0_din;
      sram_wen  = r0_wen;
    end else if (r1_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = r1_gwen;
      sram_addr = r1_addr;
      sram_din  = r1_din;
      sram_wen  = r1_wen;
    end
  end

  assign rd_data = (rd0_vld | rd1_vld) ? sram_q : '0;

endmodule

// File: doc/ct_spsram_256x144_arb.md
Name: ct_spsram_256x144_arb

Overview:
- Two-requester arbiter/sequencer in front of one 256x144 single-port SRAM instance (active-low CEN/GWEN, active-low per-bit WEN, 1-cycle read latency).
- Grants at most one access per cycle using round-robin priority.
- Returns read data with a per-requester valid flag.
- Optionally sweeps the array to zero after reset.
- Sits between the cache-side requesters (lookup, refill) and the SRAM wrapper.

Parameters:
ADDR_WIDTH, 8, SRAM address width (256 entries)
DATA_WIDTH, 144, data and bit-write-mask width
INIT_LAST, 255, last address written by the init sweep

Ports:
forever_cpuclk  input  1  clock
cpurst_b  input  1  reset; asynchronous, active-low
r0_req  input  1  requester 0 access request
r0_gwen  input  1  requester 0: 1 = read, 0 = write
r0_addr  input  8  requester 0 address
r0_din  input  144  requester 0 write data
r0_wen  input  144  requester 0 bit write mask, active-low
r0_gnt  output  1  requester 0 granted this cycle
r1_req, r1_gwen, r1_addr, r1_din, r1_wen  input  1/1/8/144/144  requester 1, same meaning as requester 0
r1_gnt  output  1  requester 1 granted this cycle
rd0_vld  output  1  rd_data belongs to a requester 0 read
rd1_vld  output  1  rd_data belongs to a requester 1 read
rd_data  output  144  read data
arb_busy  output  1  init sweep in progress; no grants
sram_cen  output  1  to SRAM CEN, active-low
sram_gwen  output  1  to SRAM GWEN
sram_addr  output  8  to SRAM A
sram_din  output  144  to SRAM D
sram_wen  output  144  to SRAM WEN
sram_q  input  144  from SRAM Q

Behaviour:
- FSM, two states: INIT and IDLE. Reset enters INIT when the feature is enabled, IDLE otherwise.
- INIT:
  - 8-bit counter starts at 0; each cycle drives sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_din=0, sram_addr=counter.
  - r0_gnt = r1_gnt = 0; arb_busy = 1.
  - After address INIT_LAST is written, go to IDLE; arb_busy = 0 in the following cycle. The counter does not wrap.
- IDLE grant rules (combinational, same cycle as request):
  - Only one request: grant it.
  - Both request: grant r0 if rr_ptr = 0, grant r1 if rr_ptr = 1.
  - rr_ptr register: reset 0. After an r0 grant it becomes 1; after an r1 grant it becomes 0; with no grant it holds.
- Request protocol:
  - A requester holds req and its fields stable until it sees gnt.
  - Access completes on the granted edge.
  - Dropping req before gnt is legal and causes no access.
- SRAM drive:
  - Granted cycle: sram_cen=0; gwen/addr/din/wen are the granted requester's fields, passed straight through.
  - No grant in IDLE: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_addr=0, sram_din=0.
- Read return:
  - rd0_vld / rd1_vld are registered. Set in the cycle after a granted read (gwen=1) by that requester; otherwise 0.
  - Latency is 1 cycle from grant.
  - rd_data = sram_q when either vld is high, else 0.
  - Writes produce no vld.
- Back-to-back: a grant every cycle is legal. A read in cycle N and a write in N+1 to the same address return the pre-write data in N+1.
- Reset values: rr_ptr=0; rd0_vld=rd1_vld=0; counter=0.
- Reset mid-INIT: restarts the sweep at address 0.
- Reset while a read is pending: that read's vld is lost.
- Outputs during reset:
  - Feature enabled: reset holds the block in INIT at counter 0, so arb_busy=1, gnt=0, and the SRAM sees a zero write to address 0.
  - Feature disabled: arb_busy=0 and grants follow the IDLE rules.
- Never two grants in one cycle.

Optional Feature:
- Macro: CT_SPSRAM_ARB_INIT_EN.
- Defined: INIT state and counter are present; the post-reset zero sweep takes 256 cycles, during which arb_busy=1 and no grants are given.
- Undefined: INIT and counter are removed; reset goes straight to IDLE; arb_busy is tied to 0; SRAM contents after reset are undefined.

Test Plan:
- Init sweep (macro on): release cpurst_b -> arb_busy=1 for exactly 256 cycles; sram_addr steps 0x00..0xFF with cen=0, gwen=0, wen=0, din=0; r0_req held high gets no gnt until arb_busy=0.
- Single write then read: r0 writes addr 0x3C, din=0x...A5A5, wen=all 0; next cycle r0 reads 0x3C -> rd0_vld=1 one cycle after the read grant, rd_data=0x...A5A5, rd1_vld=0.
- Contention: r0 and r1 request every cycle from reset -> grants alternate r0, r1, r0, r1; never both gnt high; rr_ptr toggles each cycle.
- Masked write: write all-ones to 0x10, then write 0 with wen = 0 only on bits [71:0] -> read of 0x10 returns upper 72 bits 1, lower 72 bits 0.
- Reset mid-operation: assert cpurst_b low in the cycle after an r1 read grant -> rd1_vld stays 0; with macro on, the sweep restarts at address 0x00.
- Macro off: release reset -> arb_busy=0 immediately; an r1 read in the first cycle is granted, and rd1_vld=1 in the second cycle.
